// File: rtl/branch_predict_unit.sv
// branch_predict_unit: gshare direction predictor with a direct-mapped BTB and perf counters
module branch_predict_unit #(
  parameter int GHR_W     = 8,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_uncond,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] lookup_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int BI = $clog2(BTB_DEPTH);
  localparam int TW = 30 - BI;
  localparam int PD = 1 << GHR_W;
  logic [1:0]       pht_q [PD];
  logic             btb_v_q [BTB_DEPTH];
  logic             btb_u_q [BTB_DEPTH];
  logic [TW-1:0]    btb_tag_q [BTB_DEPTH];
  logic [31:0]      btb_tgt_q [BTB_DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_valid_q, pred_taken_q;
  logic [31:0]      pred_target_q;
  logic [GHR_W-1:0] pred_ghr_q;
  logic [CNT_W-1:0] lookup_cnt_q, mispredict_cnt_q;
  logic [GHR_W-1:0] l_pi, u_pi;
  logic [BI-1:0]    l_bi, u_bi;
  logic             hit, taken, cond_hit, recover;
  logic [1:0]       pht_nx;
  logic [31:0]      tgt;
  logic             unused_ok;
  assign unused_ok = ^{lookup_pc[1:0], upd_pc[1:0]};
  assign l_pi     = lookup_pc[GHR_W+1:2] ^ ghr_q;
  assign u_pi     = upd_pc[GHR_W+1:2] ^ upd_ghr;
  assign l_bi     = lookup_pc[BI+1:2];
  assign u_bi     = upd_pc[BI+1:2];
  assign hit      = btb_v_q[l_bi] && (btb_tag_q[l_bi] == lookup_pc[31:BI+2]);
  assign taken    = hit && (btb_u_q[l_bi] || pht_q[l_pi][1]);
  assign tgt      = taken ? btb_tgt_q[l_bi] : lookup_pc + 32'd4;
  assign cond_hit = lookup_valid && hit && !btb_u_q[l_bi];
  assign recover  = upd_valid && upd_mispredict;
  assign pht_nx   = upd_taken ? (pht_q[u_pi] == 2'b11 ? 2'b11 : pht_q[u_pi] + 2'b01)
                              : (pht_q[u_pi] == 2'b00 ? 2'b00 : pht_q[u_pi] - 2'b01);
  // misprediction recovery wins over the speculative shift of a same-cycle lookup
  always_comb begin
    ghr_d = recover  ? (upd_uncond ? upd_ghr : {upd_ghr[GHR_W-2:0], upd_taken}) :
            cond_hit ? {ghr_q[GHR_W-2:0], pht_q[l_pi][1]} : ghr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) pht_q[i] <= 2'b01;
    end else if (upd_valid && !upd_uncond) begin
      pht_q[u_pi] <= pht_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_v_q[i] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      btb_v_q[u_bi]   <= 1'b1;
      btb_u_q[u_bi]   <= upd_uncond;
      btb_tag_q[u_bi] <= upd_pc[31:BI+2];
      btb_tgt_q[u_bi] <= upd_target;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q            <= '0;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      pred_ghr_q       <= '0;
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= lookup_valid;
      if (lookup_valid) begin
        pred_taken_q  <= taken;
        pred_target_q <= tgt;
        pred_ghr_q    <= ghr_q;
      end
      if (lookup_valid && !(&lookup_cnt_q)) lookup_cnt_q <= lookup_cnt_q + 1'b1;
      if (recover && !(&mispredict_cnt_q)) mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end
  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_target    = pred_target_q;
  assign pred_ghr       = pred_ghr_q;
  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
endmodule
